// File: rtl/flash_array_ctrl.sv
// Command sequencer for the 8x8 NAND flash macro: walks read, program and erase
// commands through their phase sequences and drives the array control lines.
module flash_array_ctrl #(
  parameter int T_PRE = 2,
  parameter int T_DEV = 2,
  parameter int T_SEN = 1,
  parameter int T_PGM = 4,
  parameter int T_ERS = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] ssl,
  output logic [1:0] gsl,
  output logic [3:0] wl0,
  output logic [3:0] wl1,
  output logic       sl,
  output logic       vbpw,
  output logic       sen1,
  output logic       sen2,
  output logic [3:0] out_en,
  output logic       bl_oe,
  output logic [7:0] bl_do,
  input  logic [7:0] arr_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_PRE, S_DEV, S_SEN1, S_SEN2, S_CAP,
    S_PGM, S_ERS, S_REC, S_DONE
  } state_t;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_PG  = 2'b01;
  localparam logic [1:0] OP_ER  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       busy_q, busy_d;
  logic [1:0] ssl_q, ssl_d;
  logic [1:0] gsl_q, gsl_d;
  logic [3:0] wl0_q, wl0_d;
  logic [3:0] wl1_q, wl1_d;
  logic       sl_q, sl_d;
  logic       vbpw_q, vbpw_d;
  logic       sen1_q, sen1_d;
  logic       sen2_q, sen2_d;
  logic [3:0] out_en_q, out_en_d;
  logic       bl_oe_q, bl_oe_d;
  logic [7:0] bl_do_q, bl_do_d;

  logic [1:0] str_sel;
  logic [3:0] wl_sel;
  logic [3:0] wl_bus;
  logic       rd_act;
  logic       pg_act;

  function automatic logic [7:0] load_cnt(input state_t s);
    case (s)
      S_PRE:            load_cnt = 8'(T_PRE - 1);
      S_DEV:            load_cnt = 8'(T_DEV - 1);
      S_SEN1, S_SEN2:   load_cnt = 8'(T_SEN - 1);
      S_PGM:            load_cnt = 8'(T_PGM - 1);
      S_ERS:            load_cnt = 8'(T_ERS - 1);
      default:          load_cnt = 8'd0;
    endcase
  endfunction

  // One-hot string decode of the latched (or about-to-be-latched) address.
  for (genvar gi = 0; gi < 2; gi++) begin : g_str
    assign str_sel[gi] = (addr_d[2] == gi[0]);
  end

  assign wl_sel = 4'b0001 << addr_d[1:0];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = (cmd_op == OP_ILL) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        case (op_q)
          OP_RD:   state_d = S_PRE;
          OP_PG:   state_d = S_PGM;
          OP_ER:   state_d = S_ERS;
          default: state_d = S_DONE;
        endcase
      end
      S_PRE:  if (cnt_q == 8'd0) state_d = S_DEV;
      S_DEV:  if (cnt_q == 8'd0) state_d = S_SEN1;
      S_SEN1: if (cnt_q == 8'd0) state_d = S_SEN2;
      S_SEN2: if (cnt_q == 8'd0) state_d = S_CAP;
      S_CAP: begin
        state_d     = S_REC;
        rsp_rdata_d = arr_out;
      end
      S_PGM:  if (cnt_q == 8'd0) state_d = S_REC;
      S_ERS:  if (cnt_q == 8'd0) state_d = S_REC;
      S_REC:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = load_cnt(state_d);
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so that they are registered
    // yet line up with the state they belong to.
    rd_act = (op_d == OP_RD) &&
             (state_d inside {S_SETUP, S_PRE, S_DEV, S_SEN1, S_SEN2, S_CAP});
    pg_act = (op_d == OP_PG) && (state_d inside {S_SETUP, S_PGM});

    ssl_d    = 2'b00;
    gsl_d    = 2'b00;
    wl_bus   = 4'b0000;
    sl_d     = 1'b0;
    vbpw_d   = 1'b0;
    sen1_d   = 1'b0;
    sen2_d   = 1'b0;
    out_en_d = 4'h0;
    bl_oe_d  = 1'b0;
    bl_do_d  = 8'h00;

    if (rd_act) begin
      wl_bus = ~wl_sel;
      ssl_d  = str_sel;
      gsl_d  = str_sel;
    end
    if (pg_act) begin
      wl_bus  = wl_sel;
      ssl_d   = str_sel;
      bl_oe_d = 1'b1;
      bl_do_d = wdata_d;
    end

    wl0_d = addr_d[3] ? 4'b0000 : wl_bus;
    wl1_d = addr_d[3] ? wl_bus  : 4'b0000;

    case (state_d)
      S_PRE: begin
        bl_oe_d = 1'b1;
        bl_do_d = 8'hFF;
      end
      S_SEN1: sen1_d = 1'b1;
      S_SEN2: begin
        sen1_d = 1'b1;
        sen2_d = 1'b1;
      end
      S_CAP: begin
        sen1_d   = 1'b1;
        sen2_d   = 1'b1;
        out_en_d = 4'hF;
      end
      S_ERS: begin
        sl_d   = 1'b1;
        vbpw_d = 1'b1;
      end
      default: ;
    endcase

    rsp_valid_d = (state_d == S_DONE);
    rsp_err_d   = (state_d == S_DONE) && (op_d == OP_ILL);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      op_q        <= 2'b00;
      addr_q      <= 4'h0;
      wdata_q     <= 8'h00;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
      busy_q      <= 1'b0;
      ssl_q       <= 2'b00;
      gsl_q       <= 2'b00;
      wl0_q       <= 4'h0;
      wl1_q       <= 4'h0;
      sl_q        <= 1'b0;
      vbpw_q      <= 1'b0;
      sen1_q      <= 1'b0;
      sen2_q      <= 1'b0;
      out_en_q    <= 4'h0;
      bl_oe_q     <= 1'b0;
      bl_do_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
      ssl_q       <= ssl_d;
      gsl_q       <= gsl_d;
      wl0_q       <= wl0_d;
      wl1_q       <= wl1_d;
      sl_q        <= sl_d;
      vbpw_q      <= vbpw_d;
      sen1_q      <= sen1_d;
      sen2_q      <= sen2_d;
      out_en_q    <= out_en_d;
      bl_oe_q     <= bl_oe_d;
      bl_do_q     <= bl_do_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign ssl       = ssl_q;
  assign gsl       = gsl_q;
  assign wl0       = wl0_q;
  assign wl1       = wl1_q;
  assign sl        = sl_q;
  assign vbpw      = vbpw_q;
  assign sen1      = sen1_q;
  assign sen2      = sen2_q;
  assign out_en    = out_en_q;
  assign bl_oe     = bl_oe_q;
  assign bl_do     = bl_do_q;

endmodule
